// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and state type for the multiply-path carry-propagate adder
package calc_pkg;
    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 16;
    typedef enum logic [1:0] {IDLE, ADD, DONE} cpa_state_t;
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational W-bit adder with carry in and carry out
module chunk_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
endmodule

// File: rtl/cpa_chunked.sv
// cpa_chunked: resolves a redundant sum/carry pair into binary, CHUNK bits per cycle
module cpa_chunked
    import calc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_sum,
    input  logic [WIDTH-1:0] i_in_carry,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_result,
    output logic             o_out_cout,
    output logic             o_busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    cpa_state_t       r_state;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry_vec;
    logic [WIDTH-1:0] r_result;
    logic [IW-1:0]    r_idx;
    logic             r_cy;
    logic             r_cout;
    logic [CHUNK-1:0] w_r;
    logic             w_cy;
    logic             w_accept;
    logic             w_last;
    assign o_in_ready   = (r_state == IDLE) || (r_state == DONE && i_out_ready);
    assign w_accept     = i_in_valid && o_in_ready;
    assign o_out_valid  = r_state == DONE;
    assign o_busy       = r_state != IDLE;
    assign o_out_result = r_result;
    assign o_out_cout   = r_cout;
    assign w_last       = r_idx == IW'(NCHUNK - 1);
    chunk_adder #(.W(CHUNK)) u_add (
        .i_a   (r_sum[r_idx*CHUNK +: CHUNK]),
        .i_b   (r_carry_vec[r_idx*CHUNK +: CHUNK]),
        .i_cin (r_cy),
        .o_sum (w_r),
        .o_cout(w_cy)
    );
    // A DONE-state accept restarts ADD directly, giving NCHUNK+1 cycles per result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sum       <= '0;
            r_carry_vec <= '0;
            r_result    <= '0;
            r_idx       <= '0;
            r_cy        <= 1'b0;
            r_cout      <= 1'b0;
        end else if (w_accept) begin
            r_state     <= ADD;
            r_sum       <= i_in_sum;
            r_carry_vec <= i_in_carry;
            r_idx       <= '0;
            r_cy        <= 1'b0;
        end else if (r_state == ADD) begin
            r_result[r_idx*CHUNK +: CHUNK] <= w_r;
            r_cy    <= w_cy;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            r_cout  <= w_last ? w_cy : r_cout;
            r_state <= w_last ? DONE : ADD;
        end else if (r_state == DONE && i_out_ready) begin
            r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_cpa_chunked.sv
// tb_cpa_chunked: scoreboard bench for the chunked carry-propagate adder
module tb_cpa_chunked;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [63:0] i_in_sum = '0;
    logic [63:0] i_in_carry = '0;
    logic        o_out_valid;
    logic        i_out_ready = 1'b0;
    logic [63:0] o_out_result;
    logic        o_out_cout;
    logic        o_busy;

    typedef struct {
        logic [64:0] v;
        int          t;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_rise = -1;
    bit   b2b = 1'b0;
    logic prev_v = 1'b0;

    cpa_chunked dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_sum    (i_in_sum),
        .i_in_carry  (i_in_carry),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_result(o_out_result),
        .o_out_cout  (o_out_cout),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: latency/interval on each new out_valid, result compare on each handshake
    always @(negedge clk) begin
        if (rst_n && o_out_valid && !prev_v) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_out_valid at cycle %0d with empty scoreboard", cyc);
            end else begin
                chk("latency", 65'(cyc - sbq[0].t), 65'd4);
                if (b2b && last_rise >= 0) chk("interval", 65'(cyc - last_rise), 65'd5);
                last_rise = cyc;
            end
        end
        if (rst_n && o_out_valid && i_out_ready && sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("result", {o_out_cout, o_out_result}, e.v);
        end
        prev_v = rst_n ? o_out_valid : 1'b0;
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [63:0] s, input logic [63:0] c, input logic [64:0] exp, input bit rnd);
        i_in_valid = 1'b1;
        i_in_sum   = s;
        i_in_carry = c;
        for (int k = 0; k < 200; k++) begin
            if (rnd) i_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (o_in_ready) begin
                sbq.push_back('{v: exp, t: cyc + 1});
                @(posedge clk);
                #1;
                i_in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        failures++;
        $display("FAIL send_timeout in_ready=%b required=1", o_in_ready);
        i_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            if (sbq.size() == 0 && !o_busy) return;
            @(posedge clk);
            #1;
        end
        checks++;
        failures++;
        $display("FAIL idle_timeout pending=%0d busy=%b required pending=0 busy=0", sbq.size(), o_busy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] s;
        logic [63:0] c;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 65'(o_in_ready), 65'd1);
        chk("rst_out_valid", 65'(o_out_valid), 65'd0);
        chk("rst_busy", 65'(o_busy), 65'd0);
        chk("rst_result", {o_out_cout, o_out_result}, 65'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(64'h0000_0000_FFFF_FFFF, 64'h1, 65'h0_0000_0001_0000_0000, 1'b0);
        wait_idle();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 65'h1_0000_0000_0000_0000, 1'b0);
        wait_idle();
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65'h1_0000_0000_0000_0000, 1'b0);
        wait_idle();
        send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1110, 65'h0_1234_5678_9ABC_DEFF, 1'b0);
        wait_idle();
        send(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 65'h0_0001_0000_0001_0000, 1'b0);
        wait_idle();
        // Backpressure: hold result in DONE while a new pair waits
        i_out_ready = 1'b0;
        send(64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001, 65'h0_0000_0000_0000_0100, 1'b0);
        for (int k = 0; k < 20 && !o_out_valid; k++) begin
            @(posedge clk);
            #1;
        end
        i_in_valid = 1'b1;
        i_in_sum   = 64'hAAAA_AAAA_AAAA_AAAA;
        i_in_carry = 64'h5555_5555_5555_5556;
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", 65'(o_out_valid), 65'd1);
            chk("bp_hold", {o_out_cout, o_out_result}, 65'h0_0000_0000_0000_0100);
            chk("bp_in_ready", 65'(o_in_ready), 65'd0);
            @(posedge clk);
            #1;
        end
        i_out_ready = 1'b1;
        send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5556, 65'h1_0000_0000_0000_0000, 1'b0);
        wait_idle();
        // Reset during chunk 2 discards the operation
        send(64'hDEAD_BEEF_0000_0001, 64'h1, 65'h0_DEAD_BEEF_0000_0002, 1'b0);
        chk("busy_add", 65'(o_busy), 65'd1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("mid_rst_out_valid", 65'(o_out_valid), 65'd0);
        chk("mid_rst_busy", 65'(o_busy), 65'd0);
        chk("mid_rst_in_ready", 65'(o_in_ready), 65'd1);
        chk("mid_rst_result", {o_out_cout, o_out_result}, 65'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(64'h1234, 64'h10, 65'h1244, 1'b0);
        wait_idle();
        // Back-to-back with out_ready held high
        b2b = 1'b1;
        last_rise = -1;
        for (int n = 0; n < 20; n++) begin
            s = {$urandom, $urandom};
            c = {$urandom, $urandom};
            send(s, c, {1'b0, s} + {1'b0, c}, 1'b0);
        end
        wait_idle();
        b2b = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            s = {$urandom, $urandom};
            c = {$urandom, $urandom};
            send(s, c, {1'b0, s} + {1'b0, c}, 1'b1);
        end
        i_out_ready = 1'b1;
        wait_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
